// File: rtl/sprite_pkg.sv
// Shared types and constants for the glyph sprite ROMs and the scan-out blitter.
package sprite_pkg;

  localparam int COLOR_W = 10;
  localparam int SPR_W   = 32;
  localparam int SPR_H   = 24;
  localparam int COL_W   = $clog2(SPR_W);
  localparam int ROW_W   = $clog2(SPR_H);

  localparam logic [COLOR_W-1:0] KEY_COLOR = 10'd391;

  // Row-major colour array, row 0 at the top; also the sprite ROM output type.
  typedef logic [0:SPR_H-1][0:SPR_W-1][COLOR_W-1:0] sprite_arr_t;

  typedef enum logic [1:0] {
    HIDDEN      = 2'd0,
    HIDDEN_PEND = 2'd1,
    SHOWN       = 2'd2,
    SHOWN_PEND  = 2'd3
  } blit_state_t;

  function automatic logic state_is_shown(input blit_state_t st);
    return (st == SHOWN) || (st == SHOWN_PEND);
  endfunction

  function automatic logic state_is_ready(input blit_state_t st);
    return (st == HIDDEN) || (st == SHOWN);
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// First scan-out stage: offset of the beam from the sprite origin, box test and
// scale-down to a sprite row/column. Shared with the collision logic.
module sprite_hit_calc
  import sprite_pkg::*;
#(
  parameter int SCALE_LOG2 = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [9:0]       draw_x,
  input  logic [9:0]       draw_y,
  input  logic             pix_valid_in,
  input  logic [9:0]       act_x,
  input  logic [9:0]       act_y,
  input  logic             shown,
  output logic             inbox,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             valid
);

  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);

  logic [10:0]      dx_s;
  logic [10:0]      dy_s;
  logic             x_in_s;
  logic             y_in_s;
  logic             inbox_s;
  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;

  // Bit 10 is the sign: a beam left of / above the origin never wraps into the box.
  assign dx_s    = {1'b0, draw_x} - {1'b0, act_x};
  assign dy_s    = {1'b0, draw_y} - {1'b0, act_y};
  assign x_in_s  = ~dx_s[10] & (dx_s < BOX_W);
  assign y_in_s  = ~dy_s[10] & (dy_s < BOX_H);
  assign inbox_s = shown & pix_valid_in & x_in_s & y_in_s;
  assign col_s   = COL_W'(dx_s >> SCALE_LOG2);
  assign row_s   = ROW_W'(dy_s >> SCALE_LOG2);

  // Stage-1 register; row/col forced to 0 outside the box so stage 2 never indexes out of range
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      inbox <= 1'b0;
      valid <= 1'b0;
      row   <= {ROW_W{1'b0}};
      col   <= {COL_W{1'b0}};
    end else begin
      inbox <= inbox_s;
      valid <= pix_valid_in;
      row   <= inbox_s ? row_s : {ROW_W{1'b0}};
      col   <= inbox_s ? col_s : {COL_W{1'b0}};
    end
  end

endmodule

// File: rtl/digit_sprite_blitter.sv
// Per-glyph scan-out reader: tear-free position updates at frame boundaries and a
// two-stage lookup producing the sprite colour or the background with key transparency.
module digit_sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SCALE_LOG2 = 0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  sprite_arr_t        sprite_rgb,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               show_req,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic               frame_start,
  input  logic [9:0]         draw_x,
  input  logic [9:0]         draw_y,
  input  logic               pix_valid_in,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_hit,
  output logic               pix_valid
);

  blit_state_t        state_r;
  blit_state_t        next_state_s;
  logic               load_pend_s;
  logic               load_act_s;
  logic               accept_s;
  logic               pos_ready_r;
  logic [9:0]         pend_x_r;
  logic [9:0]         pend_y_r;
  logic               pend_show_r;
  logic [9:0]         act_x_r;
  logic [9:0]         act_y_r;

  logic               s1_inbox_s;
  logic [ROW_W-1:0]   s1_row_s;
  logic [COL_W-1:0]   s1_col_s;
  logic               s1_valid_s;
  logic [COLOR_W-1:0] c_s;
  logic               hit_s;
  logic [COLOR_W-1:0] pix_color_r;
  logic               pix_hit_r;
  logic               pix_valid_r;

  assign accept_s = pos_valid & pos_ready_r;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= HIDDEN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: accept only in ready states, so a same-cycle frame_start is ignored
  always_comb begin
    next_state_s = state_r;
    load_pend_s  = 1'b0;
    load_act_s   = 1'b0;
    case (state_r)
      HIDDEN: begin
        if (accept_s) begin
          next_state_s = HIDDEN_PEND;
          load_pend_s  = 1'b1;
        end else begin
          next_state_s = HIDDEN;
        end
      end
      SHOWN: begin
        if (accept_s) begin
          next_state_s = SHOWN_PEND;
          load_pend_s  = 1'b1;
        end else begin
          next_state_s = SHOWN;
        end
      end
      HIDDEN_PEND, SHOWN_PEND: begin
        if (frame_start) begin
          next_state_s = pend_show_r ? SHOWN : HIDDEN;
          load_act_s   = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = HIDDEN;
      end
    endcase
  end

  // Pending/active position registers and registered ready
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_x_r    <= 10'd0;
      pend_y_r    <= 10'd0;
      pend_show_r <= 1'b0;
      act_x_r     <= 10'd0;
      act_y_r     <= 10'd0;
      pos_ready_r <= 1'b1;
    end else begin
      if (load_pend_s) begin
        pend_x_r    <= pos_x;
        pend_y_r    <= pos_y;
        pend_show_r <= show_req;
      end
      if (load_act_s) begin
        act_x_r <= pend_x_r;
        act_y_r <= pend_y_r;
      end
      pos_ready_r <= state_is_ready(next_state_s);
    end
  end

  sprite_hit_calc #(
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_hit_calc (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .pix_valid_in (pix_valid_in),
    .act_x        (act_x_r),
    .act_y        (act_y_r),
    .shown        (state_is_shown(state_r)),
    .inbox        (s1_inbox_s),
    .row          (s1_row_s),
    .col          (s1_col_s),
    .valid        (s1_valid_s)
  );

  assign c_s   = sprite_rgb[s1_row_s][s1_col_s];
  assign hit_s = s1_inbox_s & (c_s != KEY_COLOR);

  // Stage-2 output register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_color_r <= {COLOR_W{1'b0}};
      pix_hit_r   <= 1'b0;
      pix_valid_r <= 1'b0;
    end else begin
      pix_color_r <= hit_s ? c_s : bg_color;
      pix_hit_r   <= hit_s;
      pix_valid_r <= s1_valid_s;
    end
  end

  assign pos_ready = pos_ready_r;
  assign pix_color = pix_color_r;
  assign pix_hit   = pix_hit_r;
  assign pix_valid = pix_valid_r;

endmodule

// File: tb/tb_digit_sprite_blitter.sv
// Directed bench for digit_sprite_blitter: one unscaled and one 2x instance share stimulus.
module tb_digit_sprite_blitter;
  import sprite_pkg::*;

  logic               Clk = 1'b0;
  logic               Reset_n;
  sprite_arr_t        sprite_rgb;
  logic [9:0]         pos_x, pos_y;
  logic               show_req, pos_valid, frame_start, pix_valid_in;
  logic [9:0]         draw_x, draw_y;
  logic [COLOR_W-1:0] bg_color;
  logic               pos_ready0, pix_hit0, pix_valid0;
  logic               pos_ready1, pix_hit1, pix_valid1;
  logic [COLOR_W-1:0] pix_color0, pix_color1;
  int                 checks = 0;
  int                 errors = 0;

  localparam logic [COLOR_W-1:0] BG = 10'd85;

  always #5 Clk = ~Clk;

  digit_sprite_blitter #(.SCALE_LOG2(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .sprite_rgb(sprite_rgb),
    .pos_x(pos_x), .pos_y(pos_y), .show_req(show_req), .pos_valid(pos_valid),
    .pos_ready(pos_ready0), .frame_start(frame_start),
    .draw_x(draw_x), .draw_y(draw_y), .pix_valid_in(pix_valid_in), .bg_color(bg_color),
    .pix_color(pix_color0), .pix_hit(pix_hit0), .pix_valid(pix_valid0)
  );

  digit_sprite_blitter #(.SCALE_LOG2(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .sprite_rgb(sprite_rgb),
    .pos_x(pos_x), .pos_y(pos_y), .show_req(show_req), .pos_valid(pos_valid),
    .pos_ready(pos_ready1), .frame_start(frame_start),
    .draw_x(draw_x), .draw_y(draw_y), .pix_valid_in(pix_valid_in), .bg_color(bg_color),
    .pix_color(pix_color1), .pix_hit(pix_hit1), .pix_valid(pix_valid1)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One valid pixel, then wait out the 2-cycle latency
  task automatic draw(input logic [9:0] x, input logic [9:0] y);
    draw_x = x; draw_y = y; pix_valid_in = 1'b1;
    tick();
    pix_valid_in = 1'b0;
    tick();
  endtask

  task automatic request(input logic [9:0] x, input logic [9:0] y, input logic show);
    int n;
    pos_x = x; pos_y = y; show_req = show; pos_valid = 1'b1;
    n = 0;
    while (!pos_ready0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL request_ready_timeout got %0b exp 1", pos_ready0); end
    tick();
    pos_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (pix_color0 !== 10'd0) begin errors++; $display("FAIL reset_color got %0d exp 0", pix_color0); end
    checks++; if (pix_hit0 !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b exp 0", pix_hit0); end
    checks++; if (pix_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", pix_valid0); end
    checks++; if (pos_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", pos_ready0); end
    Reset_n = 1'b1;
    tick();
    draw(10'd0, 10'd0);
    checks++; if (pix_hit0 !== 1'b0 || pix_color0 !== BG) begin errors++; $display("FAIL hidden_draw got hit %0b col %0d exp 0 %0d", pix_hit0, pix_color0, BG); end
  endtask

  task automatic test_request_pending();
    request(10'd100, 10'd50, 1'b1);
    checks++; if (pos_ready0 !== 1'b0) begin errors++; $display("FAIL pend_ready got %0b exp 0", pos_ready0); end
    draw(10'd103, 10'd53);
    checks++; if (pix_hit0 !== 1'b0 || pix_color0 !== BG) begin errors++; $display("FAIL pend_draw got hit %0b col %0d exp 0 %0d", pix_hit0, pix_color0, BG); end
    frame();
    checks++; if (pos_ready0 !== 1'b1) begin errors++; $display("FAIL shown_ready got %0b exp 1", pos_ready0); end
  endtask

  task automatic test_lookup();
    draw(10'd103, 10'd53);
    checks++; if (pix_color0 !== 10'd430 || pix_hit0 !== 1'b1 || pix_valid0 !== 1'b1) begin errors++; $display("FAIL lookup_33 got col %0d hit %0b v %0b exp 430 1 1", pix_color0, pix_hit0, pix_valid0); end
    draw(10'd104, 10'd55);
    checks++; if (pix_color0 !== 10'd428 || pix_hit0 !== 1'b1) begin errors++; $display("FAIL lookup_54 got col %0d hit %0b exp 428 1", pix_color0, pix_hit0); end
    draw(10'd100, 10'd50);
    checks++; if (pix_color0 !== BG || pix_hit0 !== 1'b0) begin errors++; $display("FAIL lookup_key got col %0d hit %0b exp %0d 0", pix_color0, pix_hit0, BG); end
    draw(10'd132, 10'd50);
    checks++; if (pix_color0 !== BG || pix_hit0 !== 1'b0) begin errors++; $display("FAIL lookup_right got col %0d hit %0b exp %0d 0", pix_color0, pix_hit0, BG); end
    draw(10'd99, 10'd50);
    checks++; if (pix_color0 !== BG || pix_hit0 !== 1'b0) begin errors++; $display("FAIL lookup_left got col %0d hit %0b exp %0d 0", pix_color0, pix_hit0, BG); end
    draw_x = 10'd103; draw_y = 10'd53; pix_valid_in = 1'b0;
    tick(); tick();
    checks++; if (pix_color0 !== BG || pix_hit0 !== 1'b0 || pix_valid0 !== 1'b0) begin errors++; $display("FAIL lookup_invalid got col %0d hit %0b v %0b exp %0d 0 0", pix_color0, pix_hit0, pix_valid0, BG); end
  endtask

  task automatic test_back_to_back();
    pos_x = 10'd300; pos_y = 10'd200; show_req = 1'b1; pos_valid = 1'b1; frame_start = 1'b1;
    tick();
    pos_valid = 1'b0; frame_start = 1'b0;
    checks++; if (pos_ready0 !== 1'b0) begin errors++; $display("FAIL same_cycle_ready got %0b exp 0", pos_ready0); end
    draw(10'd103, 10'd53);
    checks++; if (pix_color0 !== 10'd430) begin errors++; $display("FAIL same_cycle_old got %0d exp 430", pix_color0); end
    draw(10'd303, 10'd203);
    checks++; if (pix_hit0 !== 1'b0) begin errors++; $display("FAIL same_cycle_new_early got %0b exp 0", pix_hit0); end
    frame();
    draw(10'd303, 10'd203);
    checks++; if (pix_color0 !== 10'd430 || pix_hit0 !== 1'b1) begin errors++; $display("FAIL second_frame_new got col %0d hit %0b exp 430 1", pix_color0, pix_hit0); end
    draw(10'd103, 10'd53);
    checks++; if (pix_hit0 !== 1'b0) begin errors++; $display("FAIL second_frame_old got %0b exp 0", pix_hit0); end
  endtask

  task automatic test_clip();
    request(10'd620, 10'd470, 1'b1);
    frame();
    draw(10'd639, 10'd479);
    checks++; if (pix_color0 !== 10'd500 || pix_hit0 !== 1'b1) begin errors++; $display("FAIL clip_corner got col %0d hit %0b exp 500 1", pix_color0, pix_hit0); end
    draw(10'd0, 10'd0);
    checks++; if (pix_hit0 !== 1'b0 || pix_color0 !== BG) begin errors++; $display("FAIL clip_nowrap got hit %0b col %0d exp 0 %0d", pix_hit0, pix_color0, BG); end
  endtask

  task automatic test_scale();
    logic [9:0] xs [4];
    logic [9:0] ys [4];
    xs = '{10'd6, 10'd7, 10'd6, 10'd7};
    ys = '{10'd6, 10'd7, 10'd7, 10'd6};
    request(10'd0, 10'd0, 1'b1);
    frame();
    for (int i = 0; i < 4; i++) begin
      draw(xs[i], ys[i]);
      checks++; if (pix_color1 !== 10'd430 || pix_hit1 !== 1'b1) begin errors++; $display("FAIL scale_%0d_%0d got col %0d hit %0b exp 430 1", xs[i], ys[i], pix_color1, pix_hit1); end
    end
    draw(10'd64, 10'd0);
    checks++; if (pix_hit1 !== 1'b0 || pix_color1 !== BG) begin errors++; $display("FAIL scale_edge got hit %0b col %0d exp 0 %0d", pix_hit1, pix_color1, BG); end
  endtask

  task automatic test_async_reset();
    draw_x = 10'd3; draw_y = 10'd3; pix_valid_in = 1'b1;
    tick(); tick();
    checks++; if (pix_hit0 !== 1'b1 || pix_color0 !== 10'd430) begin errors++; $display("FAIL pre_reset_hit got hit %0b col %0d exp 1 430", pix_hit0, pix_color0); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (pix_hit0 !== 1'b0 || pix_valid0 !== 1'b0 || pix_color0 !== 10'd0) begin errors++; $display("FAIL async_clear got hit %0b v %0b col %0d exp 0 0 0", pix_hit0, pix_valid0, pix_color0); end
    #1 Reset_n = 1'b1;
    tick(); tick();
    checks++; if (pix_hit0 !== 1'b0 || pix_valid0 !== 1'b1 || pix_color0 !== BG || pos_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset got hit %0b v %0b col %0d rdy %0b exp 0 1 %0d 1", pix_hit0, pix_valid0, pix_color0, pos_ready0, BG); end
    request(10'd0, 10'd0, 1'b1);
    tick(); tick();
    checks++; if (pix_hit0 !== 1'b0) begin errors++; $display("FAIL post_reset_pend got %0b exp 0", pix_hit0); end
    frame();
    tick(); tick();
    checks++; if (pix_hit0 !== 1'b1 || pix_color0 !== 10'd430) begin errors++; $display("FAIL post_reset_show got hit %0b col %0d exp 1 430", pix_hit0, pix_color0); end
    pix_valid_in = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    pos_x = 10'd0; pos_y = 10'd0; show_req = 1'b0; pos_valid = 1'b0; frame_start = 1'b0;
    draw_x = 10'd0; draw_y = 10'd0; pix_valid_in = 1'b0; bg_color = BG;
    for (int r = 0; r < SPR_H; r++)
      for (int c = 0; c < SPR_W; c++)
        sprite_rgb[r][c] = 10'd391;
    sprite_rgb[3][3]  = 10'd430;
    sprite_rgb[5][4]  = 10'd428;
    sprite_rgb[9][19] = 10'd500;

    test_reset();
    test_request_pending();
    test_lookup();
    test_back_to_back();
    test_clip();
    test_scale();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_sprite_blitter.md
Name: digit_sprite_blitter

Overview:
Scan-out reader for the fixed digit/glyph sprite ROM modules: a 24x32 array of 10-bit colour codes. Given the VGA controller's current pixel coordinate, it decides whether the pixel lies inside the sprite's on-screen box and looks up the sprite colour. Colour KEY_COLOR is treated as transparent. Sprite position changes are accepted through a valid/ready handshake and take effect only at frame boundaries, so a frame never tears. It sits between the VGA controller and the colour mapper, one instance per on-screen glyph.

Parameters:
SPR_W, 32, sprite width in pixels (columns)
SPR_H, 24, sprite height in pixels (rows)
COLOR_W, 10, colour code width
KEY_COLOR, 391, transparent colour code
SCALE_LOG2, 0, integer upscale: each sprite pixel is drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels (legal values 0..2)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
sprite_rgb  in  [COLOR_W-1:0] x [0:SPR_H-1][0:SPR_W-1]  sprite colour array, row-major, row 0 at top
pos_x  in  10  requested sprite left edge, screen X
pos_y  in  10  requested sprite top edge, screen Y
show_req  in  1  1 = request shown, 0 = request hidden; sampled together with pos_*
pos_valid  in  1  position/show request valid
pos_ready  out  1  request can be accepted
frame_start  in  1  single-cycle pulse at start of vertical blank
draw_x  in  10  current pixel X from the VGA controller
draw_y  in  10  current pixel Y from the VGA controller
pix_valid_in  in  1  draw_x/draw_y valid (active video)
bg_color  in  [COLOR_W-1:0]  colour used when no opaque sprite pixel is present
pix_color  out  [COLOR_W-1:0]  output colour
pix_hit  out  1  output pixel came from an opaque sprite pixel
pix_valid  out  1  pix_valid_in delayed to align with pix_color

Behaviour:
- Reset (asynchronous, Reset_n=0): state HIDDEN; active position (0,0); pending registers 0; pos_ready=1; pix_color=0; pix_hit=0; pix_valid=0; both pipeline stages cleared. Reset asserted mid-frame clears all outputs immediately, without waiting for a clock edge.
- FSM states: HIDDEN, HIDDEN_PEND, SHOWN, SHOWN_PEND.
- pos_ready=1 only in HIDDEN or SHOWN.
- Accept: a request is accepted when pos_valid & pos_ready at a rising edge. pos_x, pos_y and show_req are latched into pending registers, and the state moves to the *_PEND state of the current state.
- In a *_PEND state, frame_start copies pending into active. Next state is SHOWN if pending show_req=1, otherwise HIDDEN.
- frame_start in HIDDEN or SHOWN: no change.
- Accept and frame_start in the same cycle: the accept wins. The state enters *_PEND, and the new values apply at the next frame_start, not the current one.
- pos_valid held high while pos_ready=0 is not accepted. The requester must hold its request until ready.
- Pipeline stage 1 (registered):
  - dx = {1'b0,draw_x} - {1'b0,act_x}, 11-bit signed; dy is computed the same way.
  - inbox = shown & pix_valid_in & dx>=0 & dx<(SPR_W<<SCALE_LOG2) & dy>=0 & dy<(SPR_H<<SCALE_LOG2).
  - col = dx>>SCALE_LOG2 and row = dy>>SCALE_LOG2 are registered together with inbox and pix_valid_in.
  - No wrap-around: a sprite extending past X=639 or Y=479 is clipped, never wrapped to the left or top.
- Pipeline stage 2 (registered):
  - c = sprite_rgb[row][col].
  - pix_hit = inbox & (c != KEY_COLOR).
  - pix_color = pix_hit ? c : bg_color.
  - pix_valid follows the stage-1 valid.
- Latency: exactly 2 Clk cycles from draw_x/draw_y/pix_valid_in to pix_color/pix_hit/pix_valid.
- When pix_valid_in=0: stage-2 outputs pix_color=bg_color, pix_hit=0, pix_valid=0.
- "shown" means state is SHOWN or SHOWN_PEND; the active position is used in both.

Decomposition:
- Shared package sprite_pkg:
  - COLOR_W and KEY_COLOR constants
  - SPR_W and SPR_H constants
  - the typedef for the colour array type, also used by the sprite ROM modules
  - the enum for the FSM state
- One sub-module: sprite_hit_calc. It holds stage 1 (the offset subtraction, box test and scale shift) so it can be reused by the collision logic.
- The FSM and stage 2 stay in the top module.

Test Plan:
- Reset, then request (100,50) with show=1 mid-frame → pos_ready falls to 0 one cycle after the accept. Draw (100,50) before frame_start: pix_color=bg_color, pix_hit=0. After frame_start: SHOWN and pos_ready=1.
- Sprite array all 391 except [3][3]=430 and [5][4]=428; sprite at (100,50), SCALE_LOG2=0. Draw (103,53) → 2 cycles later pix_color=430, pix_hit=1. Draw (104,55) → 428. Draw (100,50) → bg_color, pix_hit=0 (key colour). Draw (132,50) and (99,50) → bg_color.
- Accept and frame_start in the same cycle → active position unchanged. The state changes only on the second frame_start.
- Sprite at (620,470) → draw (639,479) maps to [9][19]. Draw (0,0) never hits (no wrap).
- SCALE_LOG2=1, sprite at (0,0) → draws (6,6), (7,7), (6,7) and (7,6) all return [3][3]=430. Draw (64,0) misses.
- Reset_n asserted while pix_valid=1 and pix_hit=1 → outputs are 0 immediately (asynchronous). After release: HIDDEN, pos_ready=1, and no hits until a new show request and frame_start.
